uart_tx_arbiter: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: state encoding, byte width
// and a constant-friendly clog2.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } uart_arb_state_e;

  // Ceiling log2, never below 1 so every counter/index keeps at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping modulo NREQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW:0]      sum;

  // Rotate so bit 0 is rr_ptr, take the lowest set bit, map back to an index.
  always_comb begin
    dbl       = {req_valid, req_valid} >> rr_ptr;
    rot       = dbl[NREQ-1:0];
    sum       = '0;
    any_valid = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum       = {1'b0, rr_ptr} + (IDW+1)'(j);
        any_valid = 1'b1;
      end
    end
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    winner = sum[IDW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer between NREQ byte
// producers. IDLE accepts one byte, LOAD fires tx_start once the serializer
// is free, WAIT watches for tx_done (or times out), GAP enforces idle time.
// Optional packet lock is compiled in with `define UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ           = 4,
  parameter  int GAP_CYCLES     = 16,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int IDW            = clog2(NREQ)
) (
  input  logic                        sysclk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             req_ready,
  output logic [IDW-1:0]              grant_id,
  output logic [UART_DATA_W-1:0]      tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic                        timeout_o
);

  localparam int TOW = clog2(TIMEOUT_CYCLES + 1);
  localparam int GW  = clog2(GAP_CYCLES + 1);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  uart_arb_state_e        state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [TOW-1:0]         to_cnt_q, to_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;

  logic [IDW-1:0]         pick_winner;
  logic                   pick_any;
  logic [IDW-1:0]         winner;
  logic                   take;
  logic [IDW-1:0]         nxt_ptr;
  logic [NREQ-1:0]        win_oh;
  logic [UART_DATA_W-1:0] sel_data;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  // Packet lock register: set while a multi-byte packet is in flight.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end
`else
  logic lock_q;
  logic unused_req_last;
  assign lock_q          = 1'b0;
  assign unused_req_last = ^req_last;
`endif

  uart_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (pick_winner),
    .any_valid (pick_any)
  );

  // Winner selection: a held lock pins the grant to the current owner.
  always_comb begin
    winner   = lock_q ? grant_id_q : pick_winner;
    take     = lock_q ? req_valid[grant_id_q] : pick_any;
    nxt_ptr  = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    win_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        win_oh[i] = 1'b1;
        sel_data  = req_data[i*UART_DATA_W +: UART_DATA_W];
      end
    end
  end

  // Next-state and output logic for the IDLE/LOAD/WAIT/GAP machine.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    req_ready  = '0;
    tx_start   = 1'b0;
    timeout_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // reset_n gate keeps ready low while reset is held with valid high.
        if (take && reset_n) begin
          req_ready  = win_oh;
          tx_data_d  = sel_data;
          grant_id_d = winner;
          state_d    = LOAD;
`ifdef UART_ARB_LOCK_EN
          lock_d = ~req_last[winner];
          if (req_last[winner]) rr_ptr_d = nxt_ptr;
`else
          rr_ptr_d = nxt_ptr;
`endif
        end
      end
      LOAD: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          to_cnt_d = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // tx_done takes priority over a timeout landing in the same cycle.
        if (tx_done) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
`ifdef UART_ARB_LOCK_EN
          lock_d = 1'b0;
`endif
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, captured byte and counters.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign tx_data  = tx_data_q;

endmodule
